// File: rtl/mem_dump_unit_pkg.sv
// Shared definitions for the RISC_SPM memory dump unit: default widths and
// the dump FSM state encoding.
package mem_dump_unit_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } dump_state_e;

endpackage

// File: rtl/mem_dump_unit.sv
// Memory dump unit: walks an inclusive address range (wrapping modulo
// 2^ADDR_W), reads each word from a one-cycle-latency memory, presents it on
// a valid/ready stream with its address, and accumulates a modular checksum.
// All outputs come straight from flops; their next values are derived from
// the next FSM state so they line up with the state they describe.
module mem_dump_unit
    import mem_dump_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] dout_addr,
    output logic              dout_valid,
    input  logic              dout_ready
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [ADDR_W-1:0] dout_addr_q, dout_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              dout_valid_q, dout_valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    // State, datapath and output registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            end_q        <= '0;
            checksum_q   <= '0;
            dout_q       <= '0;
            dout_addr_q  <= '0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            end_q        <= end_d;
            checksum_q   <= checksum_d;
            dout_q       <= dout_d;
            dout_addr_q  <= dout_addr_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            dout_valid_q <= dout_valid_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic plus address counter, word capture and checksum.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        end_d       = end_q;
        checksum_d  = checksum_q;
        dout_d      = dout_q;
        dout_addr_d = dout_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d     = start_addr;
                    end_d      = end_addr;
                    checksum_d = '0;
                    state_d    = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Read data is valid on this edge: capture it and fold it in.
                dout_d      = mem_data;
                dout_addr_d = addr_q;
                checksum_d  = checksum_q + mem_data;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (dout_ready) begin
                    if (addr_q == end_q) begin
                        state_d = ST_DONE;
                    end else begin
                        // Natural wrap at 2^ADDR_W lets start > end dump through zero.
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered output values, derived from the state being entered.
    always_comb begin
        mem_rd_d     = (state_d == ST_READ);
        dout_valid_d = (state_d == ST_OUT);
        done_d       = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
        if (state_d == ST_READ) begin
            mem_addr_d = addr_d;
        end else begin
            mem_addr_d = mem_addr_q;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign checksum   = checksum_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign dout       = dout_q;
    assign dout_addr  = dout_addr_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Self-checking bench for mem_dump_unit: a one-cycle-latency memory model,
// a stream monitor, and a reference that computes the expected word list and
// checksum directly from the requested address range.
module tb_mem_dump_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] start_addr = 8'd0;
    logic [7:0] end_addr = 8'd0;
    logic       busy;
    logic       done;
    logic [7:0] checksum;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_data = 8'd0;
    logic [7:0] dout;
    logic [7:0] dout_addr;
    logic       dout_valid;
    logic       dout_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem_arr [0:255];
    logic [15:0] obs_q[$];
    int          done_cnt = 0;
    logic [7:0]  done_cks = 8'd0;
    int          bp_mode = 0;
    int          hold_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_dout = 8'd0;
    logic [7:0]  prev_addr = 8'd0;

    mem_dump_unit #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .dout       (dout),
        .dout_addr  (dout_addr),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: data appears on the edge after the read strobe edge.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem_arr[mem_addr];
    end

    // Consumer: always ready, random ready, or stall the first word 5 cycles.
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0: dout_ready = 1'b1;
            1: dout_ready = 1'($urandom_range(0, 1));
            default: begin
                if (dout_valid && hold_cnt < 5) begin
                    dout_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    dout_ready = 1'b1;
                end
            end
        endcase
    end

    // Stream monitor: records accepted words, done pulses, stall stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check_eq("stall_valid", {31'd0, dout_valid}, 32'd1);
                check_eq("stall_dout", {24'd0, dout}, {24'd0, prev_dout});
                check_eq("stall_addr", {24'd0, dout_addr}, {24'd0, prev_addr});
            end
            if (dout_valid) check_eq("mem_rd_in_out", {31'd0, mem_rd}, 32'd0);
            if (dout_valid && dout_ready) obs_q.push_back({dout_addr, dout});
            if (done) begin
                done_cnt++;
                done_cks = checksum;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            prev_addr  = dout_addr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check_all_zero(input string nm);
        check_eq({nm, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({nm, "_done"}, {31'd0, done}, 32'd0);
        check_eq({nm, "_cks"}, {24'd0, checksum}, 32'd0);
        check_eq({nm, "_maddr"}, {24'd0, mem_addr}, 32'd0);
        check_eq({nm, "_mrd"}, {31'd0, mem_rd}, 32'd0);
        check_eq({nm, "_dout"}, {24'd0, dout}, 32'd0);
        check_eq({nm, "_daddr"}, {24'd0, dout_addr}, 32'd0);
        check_eq({nm, "_dvalid"}, {31'd0, dout_valid}, 32'd0);
    endtask

    // Run one dump and compare it against the range-walk reference.
    task automatic run_dump(input logic [7:0] sa, input logic [7:0] ea, input bit inject,
                            input string nm);
        logic [15:0] exp_q[$];
        int          sum;
        logic [7:0]  a;
        sum = 0;
        a = sa;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back({a, mem_arr[a]});
            sum = (sum + int'(mem_arr[a])) % 256;
            if (a == ea) break;
            a = a + 8'd1;
        end
        obs_q.delete();
        done_cnt = 0;
        hold_cnt = 0;
        @(posedge clk); #1;
        start_addr = sa;
        end_addr   = ea;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        start_addr = 8'($urandom);
        end_addr   = 8'($urandom);
        check_eq({nm, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check_eq({nm, "_lat_valid_early"}, {31'd0, dout_valid}, 32'd0);
        @(posedge clk); #1;
        check_eq({nm, "_lat_valid_rise"}, {31'd0, dout_valid}, 32'd1);
        for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
            @(posedge clk); #1;
            start = inject && (c == 2 || c == 6);
            if (inject) begin
                start_addr = 8'd0;
                end_addr   = 8'd14;
            end
        end
        start = 1'b0;
        check_eq({nm, "_done_seen"}, {31'd0, (done_cnt != 0)}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check_eq({nm, "_done_count"}, done_cnt, 32'd1);
        check_eq({nm, "_cks_at_done"}, {24'd0, done_cks}, sum);
        check_eq({nm, "_cks_hold"}, {24'd0, checksum}, sum);
        check_eq({nm, "_idle"}, {31'd0, busy}, 32'd0);
        check_eq({nm, "_words"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check_eq({nm, "_word"}, {16'd0, obs_q[i]}, {16'd0, exp_q[i]});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] sa;
        int         len;
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("no_self_start", {31'd0, busy}, 32'd0);

        mem_arr[128] = 8'd6; mem_arr[129] = 8'd1; mem_arr[130] = 8'd2; mem_arr[131] = 8'd0;
        run_dump(8'd128, 8'd131, 1'b0, "basic");
        check_eq("basic_cks9", {24'd0, checksum}, 32'd9);

        mem_arr[139] = 8'hF0;
        run_dump(8'd139, 8'd139, 1'b0, "single");
        check_eq("single_cksF0", {24'd0, checksum}, 32'hF0);

        mem_arr[254] = 8'd1; mem_arr[255] = 8'd2; mem_arr[0] = 8'd3; mem_arr[1] = 8'd4;
        run_dump(8'd254, 8'd1, 1'b0, "wrap");
        check_eq("wrap_cks10", {24'd0, checksum}, 32'd10);

        bp_mode = 2;
        run_dump(8'd128, 8'd131, 1'b0, "bp");
        bp_mode = 0;

        run_dump(8'd128, 8'd131, 1'b1, "ignore_start");

        // Reset during WAIT of the second word.
        @(posedge clk); #1;
        start_addr = 8'd128;
        end_addr   = 8'd131;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rstmid_in_wait_busy", {31'd0, busy}, 32'd1);
        check_eq("rstmid_in_wait_mrd", {31'd0, mem_rd}, 32'd0);
        check_eq("rstmid_in_wait_valid", {31'd0, dout_valid}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rstmid");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rstmid_no_restart", {31'd0, busy}, 32'd0);
        run_dump(8'd128, 8'd129, 1'b0, "after_rst");

        for (int t = 0; t < 10; t++) begin
            bp_mode = int'($urandom_range(0, 1));
            sa  = 8'($urandom);
            len = int'($urandom_range(1, 10));
            for (int k = 0; k < len; k++) mem_arr[8'(sa + 8'(k))] = 8'($urandom);
            run_dump(sa, 8'(sa + 8'(len - 1)), 1'($urandom_range(0, 1)), "rand");
        end
        bp_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
